// File: rtl/hc05_at_sequencer.sv
// HC-05 boot-time AT-command sequencer and UART link arbiter.
// Optional "ERROR" reply detection is enabled by defining HC05_ERR_DETECT_EN.
module hc05_at_sequencer #(
    parameter int TIMEOUT_CYCLES   = 5000000,
    parameter int MAX_RETRY        = 3,
    parameter int KEY_SETUP_CYCLES = 50000,
    parameter int GAP_CYCLES       = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic [7:0] uart_tx_data,
    output logic       uart_tx_valid,
    input  logic       uart_tx_ready,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_valid,
    input  logic [7:0] host_tx_data,
    input  logic       host_tx_valid,
    output logic       host_tx_ready,
    output logic [7:0] host_rx_data,
    output logic       host_rx_valid,
    output logic       hc05_key,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [1:0] cmd_idx
);

    localparam int TMAX_A = (TIMEOUT_CYCLES > KEY_SETUP_CYCLES) ? TIMEOUT_CYCLES : KEY_SETUP_CYCLES;
    localparam int TMAX   = (TMAX_A > GAP_CYCLES) ? TMAX_A : GAP_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int RW     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] KS_LAST  = TW'(KEY_SETUP_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_KEY_SETUP, S_SEND, S_WAIT, S_GAP, S_DONE, S_FAIL
    } state_t;

    function automatic logic [7:0] rom_byte(input logic [4:0] a);
        case (a)
            5'd0:  rom_byte = "A";
            5'd1:  rom_byte = "T";
            5'd2:  rom_byte = 8'h0D;
            5'd3:  rom_byte = 8'h0A;
            5'd4:  rom_byte = "A";
            5'd5:  rom_byte = "T";
            5'd6:  rom_byte = "+";
            5'd7:  rom_byte = "R";
            5'd8:  rom_byte = "O";
            5'd9:  rom_byte = "L";
            5'd10: rom_byte = "E";
            5'd11: rom_byte = "=";
            5'd12: rom_byte = "1";
            5'd13: rom_byte = 8'h0D;
            5'd14: rom_byte = 8'h0A;
            5'd15: rom_byte = "A";
            5'd16: rom_byte = "T";
            5'd17: rom_byte = "+";
            5'd18: rom_byte = "C";
            5'd19: rom_byte = "M";
            5'd20: rom_byte = "O";
            5'd21: rom_byte = "D";
            5'd22: rom_byte = "E";
            5'd23: rom_byte = "=";
            5'd24: rom_byte = "1";
            5'd25: rom_byte = 8'h0D;
            5'd26: rom_byte = 8'h0A;
            default: rom_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [4:0] cmd_first(input logic [1:0] i);
        case (i)
            2'd0:    cmd_first = 5'd0;
            2'd1:    cmd_first = 5'd4;
            default: cmd_first = 5'd15;
        endcase
    endfunction

    function automatic logic [4:0] cmd_last(input logic [1:0] i);
        case (i)
            2'd0:    cmd_last = 5'd3;
            2'd1:    cmd_last = 5'd14;
            default: cmd_last = 5'd26;
        endcase
    endfunction

`ifdef HC05_ERR_DETECT_EN
    function automatic logic [7:0] err_char(input logic [2:0] n);
        case (n)
            3'd0:    err_char = "E";
            3'd1:    err_char = "R";
            3'd2:    err_char = "R";
            3'd3:    err_char = "O";
            default: err_char = "R";
        endcase
    endfunction

    logic [2:0] err_cnt_q, err_cnt_d;
`endif

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    ptr_q, ptr_d;
    logic [1:0]    cmd_idx_q, cmd_idx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          o_seen_q, o_seen_d;
    logic [7:0]    host_rx_data_q, host_rx_data_d;
    logic          host_rx_valid_q, host_rx_valid_d;
    logic          hit_ok, hit_err, fwd;

    always_comb begin
        state_d         = state_q;
        timer_d         = (timer_q == '1) ? timer_q : timer_q + TW'(1);
        ptr_d           = ptr_q;
        cmd_idx_d       = cmd_idx_q;
        retry_d         = retry_q;
        o_seen_d        = o_seen_q;
`ifdef HC05_ERR_DETECT_EN
        err_cnt_d       = err_cnt_q;
`endif
        hit_ok          = 1'b0;
        hit_err         = 1'b0;
        fwd             = 1'b0;
        uart_tx_data    = 8'h00;
        uart_tx_valid   = 1'b0;
        host_tx_ready   = 1'b0;
        hc05_key        = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        fail            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_KEY_SETUP;
                    cmd_idx_d = 2'd0;
                    retry_d   = '0;
                    ptr_d     = cmd_first(2'd0);
                end
            end
            S_KEY_SETUP: begin
                hc05_key = 1'b1;
                busy     = 1'b1;
                if (timer_q == KS_LAST) state_d = S_SEND;
            end
            S_SEND: begin
                hc05_key      = 1'b1;
                busy          = 1'b1;
                uart_tx_valid = 1'b1;
                uart_tx_data  = rom_byte(ptr_q);
                if (uart_tx_ready) begin
                    if (ptr_q == cmd_last(cmd_idx_q)) begin
                        state_d  = S_WAIT;
                        o_seen_d = 1'b0;
`ifdef HC05_ERR_DETECT_EN
                        err_cnt_d = 3'd0;
`endif
                    end else begin
                        ptr_d = ptr_q + 5'd1;
                    end
                end
            end
            S_WAIT: begin
                hc05_key = 1'b1;
                busy     = 1'b1;
                if (uart_rx_valid) begin
                    hit_ok   = o_seen_q && (uart_rx_data == "K");
                    o_seen_d = (uart_rx_data == "O");
`ifdef HC05_ERR_DETECT_EN
                    if (uart_rx_data == err_char(err_cnt_q)) begin
                        if (err_cnt_q == 3'd4) begin
                            hit_err   = 1'b1;
                            err_cnt_d = 3'd0;
                        end else begin
                            err_cnt_d = err_cnt_q + 3'd1;
                        end
                    end else begin
                        err_cnt_d = (uart_rx_data == "E") ? 3'd1 : 3'd0;
                    end
`endif
                end
                // OK has priority over both timeout and an ERROR reply
                if (hit_ok) begin
                    state_d = (cmd_idx_q == 2'd2) ? S_DONE : S_GAP;
                end else if (hit_err || timer_q == TO_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RW'(1);
                        ptr_d   = cmd_first(cmd_idx_q);
                        state_d = S_SEND;
                    end else begin
                        state_d = S_FAIL;
                    end
                end
            end
            S_GAP: begin
                hc05_key = 1'b1;
                busy     = 1'b1;
                if (timer_q == GAP_LAST) begin
                    state_d   = S_SEND;
                    cmd_idx_d = cmd_idx_q + 2'd1;
                    retry_d   = '0;
                    ptr_d     = cmd_first(cmd_idx_q + 2'd1);
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d   = S_KEY_SETUP;
                    cmd_idx_d = 2'd0;
                    retry_d   = '0;
                    ptr_d     = cmd_first(2'd0);
                end else begin
                    uart_tx_data  = host_tx_data;
                    uart_tx_valid = host_tx_valid;
                    host_tx_ready = uart_tx_ready;
                    fwd           = 1'b1;
                end
            end
            S_FAIL: begin
                fail = 1'b1;
                if (start) begin
                    state_d   = S_KEY_SETUP;
                    cmd_idx_d = 2'd0;
                    retry_d   = '0;
                    ptr_d     = cmd_first(2'd0);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every state change restarts the shared timer
        if (state_d != state_q) timer_d = '0;

        host_rx_valid_d = fwd && uart_rx_valid;
        host_rx_data_d  = (fwd && uart_rx_valid) ? uart_rx_data : host_rx_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            timer_q         <= '0;
            ptr_q           <= '0;
            cmd_idx_q       <= '0;
            retry_q         <= '0;
            o_seen_q        <= 1'b0;
`ifdef HC05_ERR_DETECT_EN
            err_cnt_q       <= 3'd0;
`endif
            host_rx_data_q  <= 8'h00;
            host_rx_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            ptr_q           <= ptr_d;
            cmd_idx_q       <= cmd_idx_d;
            retry_q         <= retry_d;
            o_seen_q        <= o_seen_d;
`ifdef HC05_ERR_DETECT_EN
            err_cnt_q       <= err_cnt_d;
`endif
            host_rx_data_q  <= host_rx_data_d;
            host_rx_valid_q <= host_rx_valid_d;
        end
    end

    assign host_rx_data  = host_rx_data_q;
    assign host_rx_valid = host_rx_valid_q && (state_q == S_DONE);
    assign cmd_idx       = cmd_idx_q;

endmodule

// File: tb/tb_hc05_at_sequencer.sv
// Directed bench for hc05_at_sequencer with small timing parameters.
// The ERROR-reply scenario runs only when HC05_ERR_DETECT_EN is defined.
module tb_hc05_at_sequencer;

    localparam int TO  = 100;
    localparam int KS  = 20;
    localparam int GAP = 10;
    localparam int MR  = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] uart_tx_data;
    logic       uart_tx_valid;
    logic       uart_tx_ready;
    logic [7:0] uart_rx_data = 8'h00;
    logic       uart_rx_valid = 1'b0;
    logic [7:0] host_tx_data = 8'h00;
    logic       host_tx_valid = 1'b0;
    logic       host_tx_ready;
    logic [7:0] host_rx_data;
    logic       host_rx_valid;
    logic       hc05_key, busy, done, fail;
    logic [1:0] cmd_idx;

    logic ready_lvl = 1'b1;
    logic toggle_en = 1'b0;
    logic tog_q = 1'b0;
    assign uart_tx_ready = toggle_en ? tog_q : ready_lvl;

    hc05_at_sequencer #(
        .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR), .KEY_SETUP_CYCLES(KS), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
        .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
        .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid),
        .hc05_key(hc05_key), .busy(busy), .done(done), .fail(fail), .cmd_idx(cmd_idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) tog_q <= ~tog_q;

    logic [7:0] rom_exp [27] = '{"A", "T", 8'h0D, 8'h0A,
                                 "A", "T", "+", "R", "O", "L", "E", "=", "1", 8'h0D, 8'h0A,
                                 "A", "T", "+", "C", "M", "O", "D", "E", "=", "1", 8'h0D, 8'h0A};
    int c_first [3] = '{0, 4, 15};
    int c_len   [3] = '{4, 11, 12};

    logic [7:0] txq [$];
    always @(posedge clk) begin
        if (uart_tx_valid && uart_tx_ready) txq.push_back(uart_tx_data);
    end

    // Held-byte stability monitor for the backpressure scenario
    logic       stall_mon = 1'b0;
    logic       pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = 8'h00;
    int         stall_seen = 0, stall_bad = 0;
    always @(posedge clk) begin
        if (stall_mon) begin
            if (pv && !pr) begin
                stall_seen <= stall_seen + 1;
                if (!uart_tx_valid || uart_tx_data != pd) stall_bad <= stall_bad + 1;
            end
            pv <= uart_tx_valid;
            pr <= uart_tx_ready;
            pd <= uart_tx_data;
        end else begin
            pv <= 1'b0;
        end
    end

    int nchk = 0;
    int nerr = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int seg_err(input int off, input int cmd);
        int e = 0;
        for (int i = 0; i < c_len[cmd]; i++) begin
            if (off + i >= txq.size()) e++;
            else if (txq[off + i] != rom_exp[c_first[cmd] + i]) e++;
        end
        return e;
    endfunction

    task automatic wait_bytes(input int n, input string tag);
        int cyc = 0;
        while (txq.size() < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk_eq(tag, txq.size(), n);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        uart_rx_data  = b;
        uart_rx_valid = 1'b1;
        @(negedge clk);
        uart_rx_valid = 1'b0;
    endtask

    task automatic reply_ok();
        rx_byte("O");
        rx_byte("K");
        rx_byte(8'h0D);
        rx_byte(8'h0A);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        txq.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int cyc;
        // Reset state
        repeat (3) @(negedge clk);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_fail", fail, 0);
        chk_eq("rst_key", hc05_key, 0);
        chk_eq("rst_txv", uart_tx_valid, 0);
        chk_eq("rst_hready", host_tx_ready, 0);
        chk_eq("rst_cmdidx", cmd_idx, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Happy path
        pulse_start();
        chk_eq("ks_key", hc05_key, 1);
        chk_eq("ks_busy", busy, 1);
        wait_bytes(4, "hp_cmd0");
        repeat (10) @(negedge clk);
        reply_ok();
        wait_bytes(15, "hp_cmd1");
        chk_eq("hp_idx1", cmd_idx, 1);
        repeat (10) @(negedge clk);
        reply_ok();
        wait_bytes(27, "hp_cmd2");
        repeat (10) @(negedge clk);
        reply_ok();
        chk_eq("hp_done", done, 1);
        chk_eq("hp_busy", busy, 0);
        chk_eq("hp_fail", fail, 0);
        chk_eq("hp_key", hc05_key, 0);
        chk_eq("hp_count", txq.size(), 27);
        e = seg_err(0, 0) + seg_err(4, 1) + seg_err(15, 2);
        chk_eq("hp_bytes", e, 0);

        // Passthrough
        host_tx_data  = 8'h55;
        host_tx_valid = 1'b1;
        #1;
        chk_eq("pt_txv", uart_tx_valid, 1);
        chk_eq("pt_txd", uart_tx_data, 8'h55);
        chk_eq("pt_hready", host_tx_ready, 1);
        @(negedge clk);
        host_tx_valid = 1'b0;
        uart_rx_data  = 8'hA3;
        uart_rx_valid = 1'b1;
        #1;
        chk_eq("pt_rxv_early", host_rx_valid, 0);
        @(negedge clk);
        uart_rx_valid = 1'b0;
        chk_eq("pt_rxv", host_rx_valid, 1);
        chk_eq("pt_rxd", host_rx_data, 8'hA3);
        @(negedge clk);
        chk_eq("pt_rxv_end", host_rx_valid, 0);
        start = 1'b1;
        host_tx_valid = 1'b1;
        #1;
        chk_eq("rs_hready", host_tx_ready, 0);
        chk_eq("rs_txv", uart_tx_valid, 0);
        @(negedge clk);
        start = 1'b0;
        host_tx_valid = 1'b0;
        chk_eq("rs_key", hc05_key, 1);
        chk_eq("rs_done", done, 0);
        chk_eq("rs_busy", busy, 1);

        // Timeout retry on cmd1
        do_reset();
        pulse_start();
        wait_bytes(4, "to_cmd0");
        repeat (10) @(negedge clk);
        reply_ok();
        wait_bytes(15, "to_cmd1a");
        chk_eq("to_idx_a", cmd_idx, 1);
        repeat (50) @(negedge clk);
        chk_eq("to_no_early", txq.size(), 15);
        wait_bytes(26, "to_cmd1b");
        chk_eq("to_idx_b", cmd_idx, 1);
        repeat (10) @(negedge clk);
        reply_ok();
        wait_bytes(38, "to_cmd2");
        repeat (10) @(negedge clk);
        reply_ok();
        chk_eq("to_done", done, 1);
        chk_eq("to_fail", fail, 0);
        e = seg_err(0, 0) + seg_err(4, 1) + seg_err(15, 1) + seg_err(26, 2);
        chk_eq("to_bytes", e, 0);

        // Retry exhaustion on cmd0
        do_reset();
        host_tx_valid = 1'b1;
        pulse_start();
        wait_bytes(16, "ex_4sends");
        repeat (50) @(negedge clk);
        chk_eq("ex_not_early", fail, 0);
        cyc = 0;
        while (!fail && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk_eq("ex_fail", fail, 1);
        chk_eq("ex_count", txq.size(), 16);
        e = seg_err(0, 0) + seg_err(4, 0) + seg_err(8, 0) + seg_err(12, 0);
        chk_eq("ex_bytes", e, 0);
        chk_eq("ex_done", done, 0);
        chk_eq("ex_busy", busy, 0);
        chk_eq("ex_key", hc05_key, 0);
        chk_eq("ex_hready", host_tx_ready, 0);
        chk_eq("ex_txv", uart_tx_valid, 0);
        rx_byte(8'hA3);
        chk_eq("ex_rxv", host_rx_valid, 0);
        host_tx_valid = 1'b0;

        // Backpressure and matcher edge cases
        do_reset();
        toggle_en = 1'b1;
        stall_mon = 1'b1;
        pulse_start();
        wait_bytes(4, "bp_cmd0a");
        rx_byte("O");
        rx_byte("X");
        rx_byte("K");
        repeat (30) @(negedge clk);
        chk_eq("oxk_nomatch", txq.size(), 4);
        chk_eq("oxk_idx", cmd_idx, 0);
        wait_bytes(8, "bp_cmd0b");
        repeat (5) @(negedge clk);
        rx_byte("O");
        rx_byte("O");
        rx_byte("K");
        wait_bytes(19, "ook_cmd1");
        chk_eq("ook_idx", cmd_idx, 1);
        toggle_en = 1'b0;
        stall_mon = 1'b0;
        chk_eq("stall_bad", stall_bad, 0);
        chk_eq("stall_seen", (stall_seen > 0), 1);
        e = seg_err(0, 0) + seg_err(4, 0) + seg_err(8, 1);
        chk_eq("bp_bytes", e, 0);

        // Asynchronous reset while a byte is held in SEND
        do_reset();
        ready_lvl = 1'b0;
        pulse_start();
        cyc = 0;
        while (!uart_tx_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk_eq("ar_sending", uart_tx_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_eq("ar_txv", uart_tx_valid, 0);
        chk_eq("ar_key", hc05_key, 0);
        chk_eq("ar_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        ready_lvl = 1'b1;

`ifdef HC05_ERR_DETECT_EN
        // ERROR reply to cmd2 forces an immediate resend
        do_reset();
        pulse_start();
        wait_bytes(4, "er_cmd0");
        repeat (10) @(negedge clk);
        reply_ok();
        wait_bytes(15, "er_cmd1");
        repeat (10) @(negedge clk);
        reply_ok();
        wait_bytes(27, "er_cmd2");
        repeat (5) @(negedge clk);
        rx_byte("E");
        rx_byte("R");
        rx_byte("R");
        rx_byte("O");
        rx_byte("R");
        chk_eq("er_resend_v", uart_tx_valid, 1);
        chk_eq("er_resend_d", uart_tx_data, "A");
        chk_eq("er_idx", cmd_idx, 2);
        wait_bytes(39, "er_cmd2b");
        repeat (10) @(negedge clk);
        reply_ok();
        chk_eq("er_done", done, 1);
        e = seg_err(27, 2);
        chk_eq("er_bytes", e, 0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
